// File: rtl/sorted_serializer.sv
`default_nettype none
// ============================================================================
// Module   : sorted_serializer
// Purpose  : Captures an N-element sorted vector and presents it one element
//            per handshake on a valid/ready stream, smallest first by default.
// Revision : 1.0  initial release
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   in_data    in   DW*N   sorted vector, element r at [DW*(r+1)-1:DW*r]
//   in_valid   in   1      in_data holds a vector to load
//   in_ready   out  1      vector accepted this cycle
//   out_data   out  DW     element currently presented
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      downstream accepts the element
//   out_last   out  1      final element of the vector
//   out_idx    out  clog2(N) index of the element currently presented
//
// Build option
//   SORTED_SERIALIZER_DESCEND_EN : emit largest first (index N-1 down to 0).
// ============================================================================
module sorted_serializer #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DW*N-1:0]       in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [$clog2(N)-1:0]  out_idx
);

    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] ONE_STEP = IW'(1);

`ifdef SORTED_SERIALIZER_DESCEND_EN
    localparam logic [IW-1:0] START_IDX = IW'(N - 1);
    localparam logic [IW-1:0] END_IDX   = '0;
`else
    localparam logic [IW-1:0] START_IDX = '0;
    localparam logic [IW-1:0] END_IDX   = IW'(N - 1);
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [IW-1:0]       idx;
    logic [DW*N-1:0]     data_reg;
    logic [DW-1:0]       elem [N];
    logic                load;
    logic                out_hs;

    // Unpack the captured vector so an element is selected by plain indexing.
    for (genvar r = 0; r < N; r++) begin : g_elem
        assign elem[r] = data_reg[DW*r +: DW];
    end

    assign load   = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        out_idx    = '0;
        in_ready   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = (idx == END_IDX);
                out_data  = elem[idx];
                out_idx   = idx;
                // A new vector may only enter on the final handshake, which
                // keeps the stream gap-free between consecutive vectors.
                in_ready  = out_ready && out_last;
                if (out_ready && out_last && !in_valid) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx      <= START_IDX;
            data_reg <= '0;
        end else if (load) begin
            idx      <= START_IDX;
            data_reg <= in_data;
        end else if (out_hs && !out_last) begin
`ifdef SORTED_SERIALIZER_DESCEND_EN
            idx <= idx - ONE_STEP;
`else
            idx <= idx + ONE_STEP;
`endif
        end
    end

endmodule
`default_nettype wire
